// File: rtl/color_cmd_parser_pkg.sv
// -----------------------------------------------------------------------------
// color_cmd_parser_pkg
// Shared definitions for the colour command parser: parser state encoding,
// default frame header byte, frame length and small helper functions.
// -----------------------------------------------------------------------------
package color_cmd_parser_pkg;

    // Parser FSM states: waiting for header, header seen, address/data seen.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GOT_SYNC = 2'd1,
        ST_GOT_AD   = 2'd2
    } parse_state_e;

    // Default frame header byte.
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    // Bytes per write frame: header, {addr,data}, inverted {addr,data}.
    localparam int FRAME_LEN = 3;

    // Frame check byte must be the bitwise inverse of the address/data byte.
    function automatic logic checksum_ok(input logic [7:0] ad_byte,
                                         input logic [7:0] chk_byte);
        return (chk_byte == ~ad_byte);
    endfunction

    // 8-bit increment that sticks at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage : color_cmd_parser_pkg

// File: rtl/color_cmd_parser_if.sv
// -----------------------------------------------------------------------------
// color_cmd_parser_if
// Register-file write port carried from the parser to the colour register file.
//   address : write address (head of the command FIFO)
//   data    : write data    (head of the command FIFO)
//   valid   : a write is pending
//   ack     : register file accepts the pending write this cycle
// master = parser side, slave = register-file side.
// -----------------------------------------------------------------------------
interface color_cmd_parser_if;
    logic [3:0] address;
    logic [3:0] data;
    logic       valid;
    logic       ack;

    modport master (output address, output data, output valid, input ack);
    modport slave  (input address, input data, input valid, output ack);
endinterface : color_cmd_parser_if

// File: rtl/color_cmd_parser_cmd_fifo.sv
// -----------------------------------------------------------------------------
// cmd_fifo
// Synchronous FIFO holding decoded {address,data} writes.
//   clk, rst   : clock, asynchronous active-low reset
//   push       : write push_data (accepted when not full, or when full with a
//                pop in the same cycle)
//   push_data  : entry to write
//   pop        : remove head entry (ignored when empty)
//   head_data  : current head entry, 0 when empty
//   full/empty : occupancy flags
//   level      : occupancy, 0..DEPTH
// Pointers carry one extra bit so full and empty are distinguishable.
// -----------------------------------------------------------------------------
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop,
    output logic [WIDTH-1:0]          head_data,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    rd_ptr_d;
    logic [PW-1:0]    level_s;
    logic             full_s;
    logic             empty_s;
    logic             pop_ok_s;
    logic             push_ok_s;

    assign level_s   = wr_ptr_q - rd_ptr_q;
    assign full_s    = (level_s == PW'(DEPTH));
    assign empty_s   = (wr_ptr_q == rd_ptr_q);

    assign level     = level_s;
    assign full      = full_s;
    assign empty     = empty_s;
    // Head is forced to zero when nothing is stored so stale entries never leak.
    assign head_data = empty_s ? {WIDTH{1'b0}} : mem_q[rd_ptr_q[AW-1:0]];

    // Next-state for storage and pointers; a pop at full frees the slot the push reuses.
    always_comb begin
        pop_ok_s  = pop && !empty_s;
        push_ok_s = push && (!full_s || pop_ok_s);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '{default: {WIDTH{1'b0}}};
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule : cmd_fifo

// File: rtl/color_cmd_parser.sv
// -----------------------------------------------------------------------------
// color_cmd_parser
// Parses 3-byte write frames (SYNC, {addr,data}, ~{addr,data}) from the UART
// byte stream, buffers good writes in a FIFO and presents them on the colour
// register file's valid/ack write port.
//   clk, rst   : clock, asynchronous active-low reset
//   rx_data    : received byte, qualified by rx_valid
//   rx_valid   : one-cycle strobe per received byte
//   wr         : register-file write port (address, data, valid, ack)
//   frame_err  : one-cycle pulse on bad check byte or inter-byte timeout
//   overflow   : sticky, a good frame was dropped because the FIFO was full
//   err_count  : saturating count of frame errors plus dropped frames
//   fifo_level : FIFO occupancy, 0..FIFO_DEPTH
// -----------------------------------------------------------------------------
module color_cmd_parser
    import color_cmd_parser_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter int         TIMEOUT    = 100000,
    parameter logic [7:0] SYNC       = SYNC_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    color_cmd_parser_if.master           wr,
    output logic                         frame_err,
    output logic                         overflow,
    output logic [7:0]                   err_count,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

    localparam int              TMR_W        = $clog2(TIMEOUT + 1);
    // Timer value at which one more idle cycle means TIMEOUT cycles elapsed.
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT - 1);

    parse_state_e     state_q;
    parse_state_e     state_d;
    logic [7:0]       byte1_q;
    logic [7:0]       byte1_d;
    logic [TMR_W-1:0] timer_q;
    logic [TMR_W-1:0] timer_d;
    logic             frame_err_q;
    logic             frame_err_d;
    logic             overflow_q;
    logic             overflow_d;
    logic [7:0]       err_count_q;
    logic [7:0]       err_count_d;

    logic             good_frame_s;
    logic             bad_frame_s;
    logic             drop_s;
    logic             pop_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [7:0]       head_s;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (good_frame_s),
        .push_data (byte1_q),
        .pop       (pop_s),
        .head_data (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .level     (fifo_level)
    );

    assign pop_s      = wr.ack && !fifo_empty_s;
    assign wr.valid   = !fifo_empty_s;
    assign wr.address = head_s[7:4];
    assign wr.data    = head_s[3:0];

    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;
    assign err_count  = err_count_q;

    // Frame parser FSM with inter-byte timer; a received byte always wins over a timeout.
    always_comb begin
        state_d      = state_q;
        byte1_d      = byte1_q;
        timer_d      = timer_q;
        good_frame_s = 1'b0;
        bad_frame_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timer_d = {TMR_W{1'b0}};
                if (rx_valid && (rx_data == SYNC)) begin
                    state_d = ST_GOT_SYNC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GOT_SYNC: begin
                if (rx_valid) begin
                    byte1_d = rx_data;
                    timer_d = {TMR_W{1'b0}};
                    state_d = ST_GOT_AD;
                end else if (timer_q >= TIMEOUT_LAST) begin
                    bad_frame_s = 1'b1;
                    timer_d     = {TMR_W{1'b0}};
                    state_d     = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_GOT_AD: begin
                if (rx_valid) begin
                    timer_d = {TMR_W{1'b0}};
                    // Always back to IDLE: a mismatching SYNC byte is not a new header.
                    state_d = ST_IDLE;
                    if (checksum_ok(byte1_q, rx_data)) begin
                        good_frame_s = 1'b1;
                    end else begin
                        bad_frame_s = 1'b1;
                    end
                end else if (timer_q >= TIMEOUT_LAST) begin
                    bad_frame_s = 1'b1;
                    timer_d     = {TMR_W{1'b0}};
                    state_d     = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                timer_d = {TMR_W{1'b0}};
                state_d = ST_IDLE;
            end
        endcase
    end

    // Error bookkeeping; a drop only happens when full with no pop freeing a slot.
    always_comb begin
        drop_s      = good_frame_s && fifo_full_s && !pop_s;
        frame_err_d = bad_frame_s;
        overflow_d  = overflow_q | drop_s;
        if (bad_frame_s || drop_s) begin
            err_count_d = sat_inc8(err_count_q);
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Parser and error state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            byte1_q     <= 8'h00;
            timer_q     <= {TMR_W{1'b0}};
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            err_count_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            byte1_q     <= byte1_d;
            timer_q     <= timer_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            err_count_q <= err_count_d;
        end
    end

endmodule : color_cmd_parser

// File: tb/tb_color_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_color_cmd_parser
// Self-checking bench for color_cmd_parser: a table of single frames followed
// by hand-written sequences for timeout, overflow, push/pop at full and reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_color_cmd_parser;
    import color_cmd_parser_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 20;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overflow;
    logic [7:0] err_count;
    logic [2:0] fifo_level;

    color_cmd_parser_if wr_if ();

    color_cmd_parser #(
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TMO),
        .SYNC       (8'hA5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .wr         (wr_if),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .err_count  (err_count),
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic       exp_push;
        logic [3:0] exp_addr;
        logic [3:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] b1);
        send_byte(8'hA5);
        send_byte(b1);
        send_byte(~b1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          err_exp;
        logic [3:0]  nib;
        logic [7:0]  exp_seq [4];

        rst         = 1'b0;
        rx_data     = 8'h00;
        rx_valid    = 1'b0;
        wr_if.ack   = 1'b0;

        vecs[0] = '{8'hA5, 8'h3C, 8'hC3, 1'b1, 4'h3, 4'hC, 1'b0};
        vecs[1] = '{8'hA5, 8'h12, 8'h00, 1'b0, 4'h0, 4'h0, 1'b1};
        vecs[2] = '{8'hA5, 8'h12, 8'hED, 1'b1, 4'h1, 4'h2, 1'b0};
        vecs[3] = '{8'hA5, 8'hF0, 8'h0F, 1'b1, 4'hF, 4'h0, 1'b0};
        vecs[4] = '{8'hA5, 8'hA5, 8'h5A, 1'b1, 4'hA, 4'h5, 1'b0};
        vecs[5] = '{8'hA5, 8'h00, 8'hFF, 1'b1, 4'h0, 4'h0, 1'b0};
        vecs[6] = '{8'hA5, 8'h77, 8'hA5, 1'b0, 4'h0, 4'h0, 1'b1};
        vecs[7] = '{8'hA5, 8'h5A, 8'hA5, 1'b1, 4'h5, 4'hA, 1'b0};
        vecs[8] = '{8'h00, 8'h11, 8'h22, 1'b0, 4'h0, 4'h0, 1'b0};

        // Reset state
        tick();
        check("rst_valid",     wr_if.valid,   0);
        check("rst_address",   wr_if.address, 0);
        check("rst_data",      wr_if.data,    0);
        check("rst_frame_err", frame_err,     0);
        check("rst_overflow",  overflow,      0);
        check("rst_err_count", err_count,     0);
        check("rst_level",     fifo_level,    0);
        rst = 1'b1;
        tick();

        // Table-driven single frames; ack pulsed afterwards (ignored when empty)
        err_exp = 0;
        for (int i = 0; i < 9; i++) begin
            send_byte(vecs[i].b0);
            send_byte(vecs[i].b1);
            send_byte(vecs[i].b2);
            err_exp += int'(vecs[i].exp_err);
            check($sformatf("v%0d_frame_err", i), frame_err,     vecs[i].exp_err);
            check($sformatf("v%0d_valid", i),     wr_if.valid,   vecs[i].exp_push);
            check($sformatf("v%0d_level", i),     fifo_level,    {2'b00, vecs[i].exp_push});
            check($sformatf("v%0d_err_count", i), err_count,     err_exp);
            if (vecs[i].exp_push) begin
                check($sformatf("v%0d_address", i), wr_if.address, vecs[i].exp_addr);
                check($sformatf("v%0d_data", i),    wr_if.data,    vecs[i].exp_data);
            end
            tick();
            check($sformatf("v%0d_err_pulse_end", i), frame_err,   0);
            check($sformatf("v%0d_valid_hold", i),    wr_if.valid, vecs[i].exp_push);
            wr_if.ack = 1'b1;
            tick();
            wr_if.ack = 1'b0;
            check($sformatf("v%0d_valid_after_ack", i), wr_if.valid, 0);
            check($sformatf("v%0d_level_after_ack", i), fifo_level,  0);
        end

        // Timeout after header: 19 idle cycles fine, 20th fires
        send_byte(8'hA5);
        for (int k = 0; k < TMO - 1; k++) tick();
        check("tmo_not_yet", frame_err, 0);
        tick();
        check("tmo_pulse", frame_err, 1);
        err_exp++;
        check("tmo_err_count", err_count, err_exp);
        send_byte(8'h12);
        send_byte(8'hED);
        check("tmo_no_write", wr_if.valid, 0);
        check("tmo_no_err",   frame_err,   0);
        check("tmo_err_same", err_count,   err_exp);

        // Timer restarts on every byte: 15 idle cycles between bytes is fine
        send_byte(8'hA5);
        for (int k = 0; k < 15; k++) tick();
        send_byte(8'h6B);
        for (int k = 0; k < 15; k++) tick();
        check("slow_no_err", frame_err, 0);
        send_byte(8'h94);
        check("slow_valid",   wr_if.valid,   1);
        check("slow_address", wr_if.address, 4'h6);
        check("slow_data",    wr_if.data,    4'hB);
        check("slow_err_cnt", err_count,     err_exp);
        wr_if.ack = 1'b1;
        tick();
        wr_if.ack = 1'b0;

        // Overflow: five frames, no ack
        do_reset();
        for (int i = 0; i < 5; i++) begin
            nib = 4'(i);
            send_frame({nib, nib});
            check($sformatf("ovf_no_frame_err%0d", i), frame_err, 0);
            if (i == 3) begin
                check("ovf_not_yet", overflow, 0);
            end
        end
        check("ovf_level",     fifo_level, 4);
        check("ovf_flag",      overflow,   1);
        check("ovf_err_count", err_count,  1);
        wr_if.ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovf_drain_valid%0d", i), wr_if.valid,   1);
            check($sformatf("ovf_drain_addr%0d", i),  wr_if.address, i);
            tick();
        end
        wr_if.ack = 1'b0;
        check("ovf_drained", wr_if.valid, 0);
        check("ovf_sticky",  overflow,    1);

        // Push and pop in the same cycle while full
        do_reset();
        for (int i = 0; i < 4; i++) begin
            nib = 4'(i);
            send_frame({nib, 4'hF - nib});
        end
        check("pp_full", fifo_level, 4);
        send_byte(8'hA5);
        send_byte(8'h96);
        rx_data   = 8'h69;
        rx_valid  = 1'b1;
        wr_if.ack = 1'b1;
        tick();
        rx_valid  = 1'b0;
        wr_if.ack = 1'b0;
        check("pp_level",     fifo_level,    4);
        check("pp_overflow",  overflow,      0);
        check("pp_err_count", err_count,     0);
        check("pp_head",      wr_if.address, 1);
        exp_seq[0] = 8'h1E;
        exp_seq[1] = 8'h2D;
        exp_seq[2] = 8'h3C;
        exp_seq[3] = 8'h96;
        wr_if.ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("pp_drain%0d", i), {wr_if.address, wr_if.data}, exp_seq[i]);
            tick();
        end
        wr_if.ack = 1'b0;
        check("pp_drained", wr_if.valid, 0);

        // Asynchronous reset mid-frame and mid-handshake
        do_reset();
        send_frame(8'h12);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'hA5);
        send_byte(8'h12);
        send_byte(8'h00);
        send_frame(8'h34);
        send_byte(8'hA5);
        send_byte(8'h56);
        check("ar_pre_valid", wr_if.valid, 1);
        check("ar_pre_level", fifo_level,  2);
        check("ar_pre_err",   err_count,   1);
        #2;
        rst = 1'b0;
        #1;
        check("ar_valid",     wr_if.valid, 0);
        check("ar_level",     fifo_level,  0);
        check("ar_err_count", err_count,   0);
        tick();
        rst = 1'b1;
        tick();
        send_byte(8'hA9);
        check("ar_byte2_no_write", wr_if.valid, 0);
        check("ar_byte2_no_err",   frame_err,   0);
        tick();
        check("ar_byte2_err_cnt",  err_count,   0);
        check("ar_byte2_level",    fifo_level,  0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_color_cmd_parser

// File: doc/color_cmd_parser.md
Name: color_cmd_parser

Overview:
Upstream feeder of the colour register file. Takes a byte stream from the UART receiver, parses 3-byte write frames, buffers the decoded {address, data} writes in a small FIFO, and presents them on the regfile's valid/ack write port. Also detects malformed frames, inter-byte timeouts and FIFO overflow, and counts errors.

Parameters:
- FIFO_DEPTH, 4, number of buffered writes; power of two, minimum 2.
- TIMEOUT, 100000, maximum clk cycles allowed between bytes of one frame.
- SYNC, 8'hA5, frame header byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset. Assertion is asynchronous; release is synchronous to clk upstream.
- rx_data  in  8  received byte; valid only while rx_valid=1.
- rx_valid  in  1  single-cycle strobe, one per byte.
- address  out  4  regfile write address (head of FIFO).
- data  out  4  regfile write data (head of FIFO).
- valid  out  1  write pending.
- ack  in  1  regfile accepts the write.
- frame_err  out  1  one-cycle pulse on a bad checksum or a timeout.
- overflow  out  1  sticky; set when a good frame is dropped because the FIFO is full.
- err_count  out  8  saturating count of frame_err pulses plus dropped frames.
- fifo_level  out  3  current FIFO occupancy, 0..FIFO_DEPTH.

Behaviour:
- Reset (rst=0): all outputs 0, FSM in IDLE, FIFO empty, timer cleared. Reset mid-frame discards the partial frame. Reset mid-handshake drops the pending write.
- Frame format: byte0=SYNC, byte1={addr[7:4],data[3:0]}, byte2=~byte1.
- FSM states: IDLE, GOT_SYNC, GOT_AD.
  - IDLE: rx_valid with SYNC goes to GOT_SYNC. Any other byte is ignored with no error.
  - GOT_SYNC: rx_valid latches byte1 and goes to GOT_AD.
  - GOT_AD: rx_valid with byte==~byte1 is a good frame. Push the write (or drop it if the FIFO is full) and go to IDLE. A mismatch pulses frame_err and goes to IDLE. A mismatched byte equal to SYNC is not reinterpreted as a new header.
- Timeout: the timer resets on every rx_valid. In GOT_SYNC or GOT_AD, if the timer reaches TIMEOUT with no byte, pulse frame_err and go to IDLE. The timer is held at 0 in IDLE.
- Push latency: a good frame completes on the cycle byte2's rx_valid is sampled. The entry is visible at the FIFO head, with valid=1, on the next cycle when the FIFO was empty.
- Output handshake:
  - valid = FIFO not empty.
  - address and data are driven from the head entry and stay stable while valid=1 and ack=0.
  - A transfer occurs on any cycle with valid=1 and ack=1; the head is popped at that clock edge.
  - ack while valid=0 is ignored.
  - Back-to-back acks drain one entry per cycle.
- Simultaneous push and pop:
  - Both occur, and fifo_level is unchanged.
  - When full, a pop in the same cycle frees a slot, so the push succeeds and there is no overflow.
- Overflow: a push while full with no pop drops the frame, sets overflow (cleared only by reset), and increments err_count. frame_err is not pulsed.
- err_count increments by 1 per event and saturates at 255. A frame_err and a drop cannot occur in the same cycle.
- Pointers are log2(FIFO_DEPTH)+1 bits wide so full and empty can be distinguished; wrap-around is natural.

Decomposition:
- Shared package: state encodings (IDLE/GOT_SYNC/GOT_AD), default SYNC value, frame length constant.
- Sub-module: cmd_fifo, a parameterised synchronous FIFO with push/pop/full/empty/level, 8-bit entries, and the same clk/rst semantics. The parser FSM, timer and error logic stay in the top.

Test Plan:
- Good frame: send A5, 3C, C3 with ack tied 0 -> one cycle after C3, valid=1, address=3, data=C, fifo_level=1. Assert ack for 1 cycle -> valid=0 next cycle.
- Bad checksum: send A5, 12, 00 -> one frame_err pulse, err_count=1, valid stays 0. A following A5, 12, ED -> address=1, data=2.
- Timeout (TIMEOUT=20 in bench): send A5, then idle 20 cycles -> frame_err pulse, FSM in IDLE. Then send 12, ED -> no write, no error.
- Overflow: ack=0, send 5 good frames with addr 0..4 -> fifo_level=4, overflow=1, err_count=1. Drain with ack=1 -> addresses 0,1,2,3 in order on consecutive cycles.
- Simultaneous push/pop at full: FIFO full and ack=1 on the cycle byte2 of a 5th frame arrives -> no overflow, fifo_level stays 4, new entry is last out.
- Async reset mid-frame and mid-handshake: rst low between byte1 and byte2 while valid=1 -> immediately valid=0, fifo_level=0, err_count=0. After release, byte2 alone produces nothing.
